// File: rtl/or_pulse_meter_pkg.sv
// ---------------------------------------------------------------------------
// or_pulse_meter_pkg
// Shared types and constants for the OR-stage pulse meter.
//   state_t          : measurement FSM states (IDLE, MEAS)
//   W_DEFAULT        : default pulse-width result width
//   CW_DEFAULT       : default completed-pulse counter width
//   SAT_MAX_DEFAULT  : saturation value of the width counter at W_DEFAULT
//   sat_max()        : saturation value for an arbitrary width (up to 32)
// ---------------------------------------------------------------------------
package or_pulse_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int W_DEFAULT       = 8;
    localparam int CW_DEFAULT      = 8;
    localparam int SAT_MAX_DEFAULT = (1 << W_DEFAULT) - 1;

    // Largest value representable in 'width' bits.
    function automatic logic [31:0] sat_max(input int width);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < width && i < 32; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk : sampling clock, rising edge
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of delay)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/or_pulse_meter.sv
// ---------------------------------------------------------------------------
// or_pulse_meter
// Measures each high pulse on the OR-stage output a1 in clock cycles, counts
// completed pulses, and presents each width on a valid/ready result port.
// A sticky overrun flag records any result lost to back-pressure.
//
// Build option: define OR_PULSE_METER_SYNC_EN to pass a1 through a 2-flop
// synchronizer (fall-to-valid latency 3 edges, a1 may be asynchronous).
// Otherwise a1 goes through one register (latency 2 edges, a1 must be
// synchronous to clk).
//
// Parameters:
//   W  : pulse-width result width, counter saturates at 2^W-1
//   CW : completed-pulse counter width, counter wraps
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   a1          : OR-stage output being measured
//   res_ready   : consumer accepts the held result
//   res_valid   : a result is held in the output register
//   pulse_width : width of the last captured pulse, in cycles
//   pulse_count : completed pulses since reset, dropped ones included
//   overrun     : sticky, at least one result was dropped
//   busy        : a pulse is currently being measured
// ---------------------------------------------------------------------------
module or_pulse_meter
    import or_pulse_meter_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a1,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [W-1:0]  pulse_width,
    output logic [CW-1:0] pulse_count,
    output logic          overrun,
    output logic          busy
);

    localparam logic [31:0]  SAT_MAX_32 = sat_max(W);
    localparam logic [W-1:0] WIDTH_MAX  = SAT_MAX_32[W-1:0];

    state_t         state, state_next;
    logic [W-1:0]   width_cnt, width_next;
    logic           s;
    logic           prev;
    logic           rise;
    logic           fall;
    logic           capture;
    logic           accept;

`ifdef OR_PULSE_METER_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (a1),
        .q   (s)
    );
`else
    logic s_q;

    // Single sample stage; a1 is assumed synchronous to clk in this build.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= 1'b0;
        end else begin
            s_q <= a1;
        end
    end

    assign s = s_q;
`endif

    // prev resets to 0 so a1 still high after reset reads as a fresh rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= s;
        end
    end

    assign rise    = s & ~prev;
    assign fall    = ~s & prev;
    assign capture = (state == MEAS) && fall;
    assign accept  = res_valid && res_ready;
    assign busy    = (state == MEAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            width_cnt <= '0;
        end else begin
            state     <= state_next;
            width_cnt <= width_next;
        end
    end

    // The rise cycle already counts as one high cycle, so the counter starts
    // at 1 and a single-cycle pulse reports width 1.
    always_comb begin
        state_next = state;
        width_next = width_cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEAS;
                    width_next = W'(1);
                end
            end
            MEAS: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (s && (width_cnt != WIDTH_MAX)) begin
                    width_next = width_cnt + W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A capture may reload the output register in the same cycle the old
    // result is accepted, so back-to-back results need no bubble. Only a
    // capture against a held, unaccepted result is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            pulse_width <= '0;
            pulse_count <= '0;
            overrun     <= 1'b0;
        end else begin
            if (capture) begin
                pulse_count <= pulse_count + CW'(1);
            end
            if (capture && (!res_valid || res_ready)) begin
                pulse_width <= width_cnt;
                res_valid   <= 1'b1;
            end else if (accept) begin
                res_valid <= 1'b0;
            end
            if (capture && res_valid && !res_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
